// File: rtl/pipe_start_ctrl.sv
// Start-up/run controller for a circular-buffer latency pipeline: clear, pipe reset, fill, run.
// Optional macro PDEPTH_TRACK_EN: a depth change in START_PIPE/RUN forces an automatic refill.
module pipe_start_ctrl #(
  parameter int unsigned AW       = 9,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned HW       = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RESTART,
  input  logic [AW-1:0] PDEPTH,
  output logic          PIP_RST,
  output logic          WE,
  output logic          RE,
  output logic [AW-1:0] WADDR,
  output logic [AW-1:0] RADDR,
  output logic [AW-1:0] WCNT,
  output logic          RUNNING,
  output logic [2:0]    STATE
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_RESET_PIPE = 3'd2,
    S_RUN        = 3'd3,
    S_START_PIPE = 3'd4
  } state_t;

  state_t        state, nstate;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [AW-1:0] wcnt, wcnt_n;
  logic [AW-1:0] waddr, waddr_n;
  logic [AW-1:0] pd_lat, pd_lat_n;
  logic          re_q;
  logic          hold_done;
  logic          depth_change;
  logic          pip_rst_c;
  logic          we_c;

  assign hold_done = (hcnt == HW'(HOLD_CYC - 1));

`ifdef PDEPTH_TRACK_EN
  assign depth_change = (PDEPTH != pd_lat);
`else
  assign depth_change = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      hcnt   <= '0;
      wcnt   <= '0;
      waddr  <= '0;
      pd_lat <= '0;
      re_q   <= 1'b0;
    end else begin
      state  <= nstate;
      hcnt   <= hcnt_n;
      wcnt   <= wcnt_n;
      waddr  <= waddr_n;
      pd_lat <= pd_lat_n;
      re_q   <= (nstate == S_RUN);
    end
  end

  always_comb begin
    nstate    = state;
    hcnt_n    = hcnt;
    wcnt_n    = wcnt;
    waddr_n   = waddr;
    pd_lat_n  = pd_lat;
    pip_rst_c = 1'b0;
    we_c      = 1'b0;
    case (state)
      S_IDLE: begin
        hcnt_n = '0;
        if (!RESTART) nstate = S_CLEAR;
      end
      S_CLEAR: begin
        if (RESTART) begin
          nstate = S_IDLE;
          hcnt_n = '0;
        end else if (hold_done) begin
          nstate = S_RESET_PIPE;
          hcnt_n = '0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      S_RESET_PIPE: begin
        pip_rst_c = 1'b1;
        if (RESTART) begin
          nstate = S_IDLE;
          hcnt_n = '0;
        end else begin
          waddr_n = '0;
          wcnt_n  = '0;
          if (hold_done) begin
            nstate   = S_START_PIPE;
            hcnt_n   = '0;
            pd_lat_n = PDEPTH;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      S_START_PIPE: begin
        we_c = 1'b1;
        if (RESTART || depth_change) begin
          nstate = S_IDLE;
          hcnt_n = '0;
        end else begin
          waddr_n = waddr + 1'b1;
          // the fill counter stops at the depth so it reads back as the latched depth in RUN
          if (wcnt == pd_lat) nstate = S_RUN;
          else                wcnt_n = wcnt + 1'b1;
        end
      end
      S_RUN: begin
        we_c = 1'b1;
        if (RESTART || depth_change) begin
          nstate = S_IDLE;
          hcnt_n = '0;
        end else begin
          waddr_n = waddr + 1'b1;
        end
      end
      default: begin
        nstate = S_IDLE;
        hcnt_n = '0;
      end
    endcase
  end

  assign PIP_RST = pip_rst_c;
  assign WE      = we_c;
  assign RE      = re_q;
  assign WADDR   = waddr;
  assign RADDR   = waddr - pd_lat;
  assign WCNT    = wcnt;
  assign RUNNING = (state == S_RUN);
  assign STATE   = state;

endmodule

// File: tb/tb_pipe_start_ctrl.sv
// Randomized bench for pipe_start_ctrl against a timeline model (cycles since entering IDLE).
module tb_pipe_start_ctrl;
  localparam int unsigned AW   = 9;
  localparam int unsigned HOLD = 4;
  localparam int unsigned HW   = 3;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          RESTART = 1'b0;
  logic [AW-1:0] PDEPTH = '0;
  logic          PIP_RST, WE, RE, RUNNING;
  logic [AW-1:0] WADDR, RADDR, WCNT;
  logic [2:0]    STATE;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // model: k = cycles since the controller last sat in IDLE; pd = latched depth
  int unsigned k  = 0;
  int unsigned pd = 0;

  pipe_start_ctrl #(.AW(AW), .HOLD_CYC(HOLD), .HW(HW)) dut (
    .CLK(CLK), .RST(RST), .RESTART(RESTART), .PDEPTH(PDEPTH),
    .PIP_RST(PIP_RST), .WE(WE), .RE(RE), .WADDR(WADDR), .RADDR(RADDR),
    .WCNT(WCNT), .RUNNING(RUNNING), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned mstate();
    int unsigned j;
    if (k == 0)        return 0;
    if (k <= HOLD)     return 1;
    if (k <= 2 * HOLD) return 2;
    j = k - (2 * HOLD + 1);
    return (j <= pd) ? 4 : 3;
  endfunction

  task automatic check_model();
    int unsigned st, j;
    st = mstate();
    check("state",   STATE,   st);
    check("pip_rst", PIP_RST, (st == 2) ? 1 : 0);
    check("we",      WE,      (st == 3 || st == 4) ? 1 : 0);
    check("re",      RE,      (st == 3) ? 1 : 0);
    check("running", RUNNING, (st == 3) ? 1 : 0);
    if (st == 3 || st == 4) begin
      j = k - (2 * HOLD + 1);
      check("waddr", WADDR, j & MASK);
      check("wcnt",  WCNT,  (j < pd) ? j : pd);
      check("raddr", RADDR, (j - pd) & MASK);
    end
  endtask

  // at a negedge: check, drive inputs, advance model, move to next negedge
  task automatic cycle(input logic rs, input int unsigned depth);
    int unsigned st;
    check_model();
    RESTART = rs;
    PDEPTH  = depth[AW-1:0];
    st = mstate();
    if (st == 0) begin
      k = rs ? 0 : 1;
    end else if (rs) begin
      k = 0;
`ifdef PDEPTH_TRACK_EN
    end else if ((st == 3 || st == 4) && depth != pd) begin
      k = 0;
`endif
    end else begin
      if (k == 2 * HOLD) pd = depth;
      k++;
    end
    @(negedge CLK);
  endtask

  task automatic run(input int unsigned n, input int unsigned depth);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, depth);
  endtask

  initial begin
    int unsigned depth;
    int unsigned guard;
    int unsigned burst;
    repeat (3) @(negedge CLK);
    check("rst_state", STATE, 0);
    check("rst_waddr", WADDR, 0);
    check("rst_re",    RE,    0);
    RST = 1'b0;
    k = 0; pd = 0;

    // power-up with depth 5, then a one-cycle restart in RUN
    run(40, 5);
    cycle(1'b1, 5);
    run(30, 5);

    // restart exactly on the cycle the fill completes
    cycle(1'b1, 5);
    guard = 0;
    while (!(mstate() == 4 && (k - (2 * HOLD + 1)) == pd) && guard < 100) begin
      cycle(1'b0, 5);
      guard++;
    end
    check("fill_end_reached", (guard < 100) ? 1 : 0, 1);
    cycle(1'b1, 5);
    run(30, 5);

    // depth 0 and address wrap
    cycle(1'b1, 0);
    run(600, 0);

    // depth change while running
    cycle(1'b1, 5);
    run(30, 5);
    run(40, 7);
    cycle(1'b1, 7);
    run(30, 7);

    // async reset mid-fill at WCNT==3
    cycle(1'b1, 5);
    guard = 0;
    while (!(mstate() == 4 && (k - (2 * HOLD + 1)) == 3) && guard < 100) begin
      cycle(1'b0, 5);
      guard++;
    end
    check("fill3_reached", (guard < 100) ? 1 : 0, 1);
    check_model();
    RESTART = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("arst_state",   STATE,   0);
    check("arst_we",      WE,      0);
    check("arst_pip_rst", PIP_RST, 0);
    check("arst_re",      RE,      0);
    check("arst_waddr",   WADDR,   0);
    check("arst_raddr",   RADDR,   0);
    check("arst_wcnt",    WCNT,    0);
    check("arst_running", RUNNING, 0);
    @(negedge CLK);
    RST = 1'b0;
    k = 0; pd = 0;
    run(30, 5);

    // randomized traffic
    depth = 5;
    burst = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) depth = $urandom_range(0, 20);
      if ($urandom_range(0, 599) == 0) depth = MASK;
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 4);
      cycle(burst != 0, depth);
      if (burst != 0) burst--;
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
